instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch buffer between the program counter and decode.
// Default build holds one entry and issues one request per instruction.
// Define IFETCH_PREFETCH_EN for a two-entry buffer with overlapped requests.
module instr_fetch #(
  parameter int unsigned IW = 16,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  input  logic          jmp,
  output logic          pc_hold,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [IW-1:0] if_instr,
  output logic [AW-1:0] if_pc
);

`ifdef IFETCH_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, WAIT, FULL, FULL2} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;
`endif

  state_t        state_q, state_d;
  logic          armed_q;
  logic          discard_q, discard_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic [AW-1:0] pc_aligned;

  // Instruction fetches are halfword aligned
  assign pc_aligned = pc & ~AW'(1);

  // Request path is enabled from the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  // FSM state, discard flag and in-flight request address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      req_pc_q  <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      req_pc_q  <= req_pc_d;
    end
  end

`ifdef IFETCH_PREFETCH_EN

  logic          busy_q, busy_d;
  logic [IW-1:0] ent1_instr;
  logic [AW-1:0] ent1_pc;
  logic [1:0]    count_q, count_mid, count_d;
  logic          pop, got, push, issue;

  // Buffer occupancy implied by the state
  always_comb begin
    count_q = 2'd0;
    case (state_q)
      FULL:    count_q = 2'd1;
      FULL2:   count_q = 2'd2;
      default: count_q = 2'd0;
    endcase
  end

  // Request engine and occupancy; the ack cycle doubles as the next issue slot
  always_comb begin
    pop       = 1'b0;
    got       = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    count_mid = count_q;
    count_d   = count_q;
    busy_d    = busy_q;
    discard_d = discard_q;
    req_pc_d  = req_pc_q;
    imem_req  = 1'b0;
    imem_addr = req_pc_q;
    pc_hold   = 1'b1;
    state_d   = state_q;

    pop       = if_valid && if_ready && !jmp;
    got       = busy_q && imem_ack;
    push      = got && !discard_q && !jmp;
    count_mid = count_q - 2'(pop) + 2'(push);
    // A slot must be free for the response of any newly issued request
    issue     = armed_q && !jmp && (!busy_q || got) && (count_mid < 2'd2);
    busy_d    = issue || (busy_q && !got);

    if (got)                discard_d = 1'b0;
    else if (busy_q && jmp) discard_d = 1'b1;

    if (issue) req_pc_d = pc_aligned;
    imem_req  = busy_q || issue;
    imem_addr = issue ? pc_aligned : req_pc_q;
    pc_hold   = !issue;

    count_d = jmp ? 2'd0 : count_mid;
    case (count_d)
      2'd1:    state_d = FULL;
      2'd2:    state_d = FULL2;
      default: state_d = busy_d ? WAIT : IDLE;
    endcase
  end

  // Two-entry output queue; head entry drives the decode interface
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      ent1_instr <= '0;
      ent1_pc    <= '0;
    end else begin
      busy_q <= busy_d;
      if (jmp) begin
        if_valid <= 1'b0;
      end else if (pop) begin
        if (count_q == 2'd2) begin
          if_instr <= ent1_instr;
          if_pc    <= ent1_pc;
        end else if (push) begin
          if_instr <= imem_rdata;
          if_pc    <= req_pc_q;
        end else begin
          if_valid <= 1'b0;
        end
      end else if (push) begin
        if (count_q == 2'd0) begin
          if_valid <= 1'b1;
          if_instr <= imem_rdata;
          if_pc    <= req_pc_q;
        end else begin
          ent1_instr <= imem_rdata;
          ent1_pc    <= req_pc_q;
        end
      end
    end
  end

`else

  logic buf_load, buf_drop;

  // Next state, request outputs and buffer control
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req_pc_d  = req_pc_q;
    buf_load  = 1'b0;
    buf_drop  = 1'b0;
    imem_req  = 1'b0;
    imem_addr = req_pc_q;
    pc_hold   = 1'b1;

    case (state_q)
      IDLE: begin
        // A redirect this cycle means pc is stale; wait for the target
        if (armed_q && !jmp) begin
          imem_req  = 1'b1;
          imem_addr = pc_aligned;
          pc_hold   = 1'b0;
          req_pc_d  = pc_aligned;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          discard_d = 1'b0;
          if (discard_q || jmp) begin
            state_d = IDLE;
          end else begin
            buf_load = 1'b1;
            state_d  = FULL;
          end
        end else if (jmp) begin
          discard_d = 1'b1;
        end
      end
      FULL: begin
        // Redirect drops the entry; otherwise wait for decode to take it
        if (jmp || if_ready) begin
          buf_drop = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single output entry presented to decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (buf_load) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= req_pc_q;
    end else if (buf_drop) begin
      if_valid <= 1'b0;
    end
  end

`endif

endmodule
